// File: rtl/mem_loader_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_loader_ctrl : host-side initiator for the cpu external memory ports;  |
// | loads imem/dmem, runs the core for N cycles, dumps dmem.  Revision 1.0    |
// +--------------------------------------------------------------------------+
module mem_loader_ctrl #(
    parameter int IMEM_STEP = 4,
    parameter int DMEM_STEP = 8,
    parameter int LEN_W     = 32
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [63:0]      cmd_addr,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [63:0]      wr_data,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [63:0]      rd_data,
    output logic             busy,
    output logic             done,
    output logic             cpu_enable,
    output logic [63:0]      addr_ext,
    output logic             wen_ext,
    output logic             ren_ext,
    output logic [31:0]      wdata_ext,
    input  logic [31:0]      rdata_ext,
    output logic [63:0]      addr_ext_2,
    output logic             wen_ext_2,
    output logic             ren_ext_2,
    output logic [63:0]      wdata_ext_2,
    input  logic [63:0]      rdata_ext_2
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD     = 3'd1,
        S_RUN      = 3'd2,
        S_DUMP_RD  = 3'd3,
        S_DUMP_CAP = 3'd4,
        S_DUMP_OUT = 3'd5
    } state_t;

    localparam logic [1:0] OP_LOAD_I = 2'b00;
    localparam logic [1:0] OP_LOAD_D = 2'b01;
    localparam logic [1:0] OP_RUN    = 2'b10;

    state_t             state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic [63:0]        base_q, base_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   idx_q, idx_d;
    logic [63:0]        rd_data_q, rd_data_d;
    logic               done_q, done_d;
    logic               ready_en_q;

    logic               cmd_fire;
    logic               wr_fire;
    logic               rd_fire;
    logic               last_idx;
    logic [63:0]        imem_addr;
    logic [63:0]        dmem_addr;
    logic               unused_rdata_ext;

    // Instruction memory has no read path from this block.
    assign unused_rdata_ext = ^rdata_ext;

    assign cmd_fire  = cmd_valid && cmd_ready;
    assign wr_fire   = wr_valid && wr_ready;
    assign rd_fire   = rd_valid && rd_ready;
    assign last_idx  = (idx_q == (len_q - LEN_W'(1)));
    assign imem_addr = base_q + (64'(idx_q) * 64'(IMEM_STEP));
    assign dmem_addr = base_q + (64'(idx_q) * 64'(DMEM_STEP));

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        base_d    = base_q;
        len_d     = len_q;
        idx_d     = idx_q;
        rd_data_d = rd_data_q;
        done_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_fire) begin
                    op_d   = cmd_op;
                    base_d = cmd_addr;
                    len_d  = cmd_len;
                    idx_d  = '0;
                    if (cmd_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        case (cmd_op)
                            OP_LOAD_I, OP_LOAD_D: state_d = S_LOAD;
                            OP_RUN:               state_d = S_RUN;
                            default:              state_d = S_DUMP_RD;
                        endcase
                    end
                end
            end
            S_LOAD: begin
                if (wr_fire) begin
                    idx_d = idx_q + LEN_W'(1);
                    if (last_idx) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            S_RUN: begin
                idx_d = idx_q + LEN_W'(1);
                if (last_idx) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            S_DUMP_RD: begin
                state_d = S_DUMP_CAP;
            end
            S_DUMP_CAP: begin
                // Read data arrives one cycle after the ren strobe.
                rd_data_d = rdata_ext_2;
                state_d   = S_DUMP_OUT;
            end
            S_DUMP_OUT: begin
                if (rd_fire) begin
                    idx_d = idx_q + LEN_W'(1);
                    if (last_idx) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_DUMP_RD;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q    <= S_IDLE;
            op_q       <= '0;
            base_q     <= '0;
            len_q      <= '0;
            idx_q      <= '0;
            rd_data_q  <= '0;
            done_q     <= 1'b0;
            ready_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            base_q     <= base_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            rd_data_q  <= rd_data_d;
            done_q     <= done_d;
            ready_en_q <= 1'b1;
        end
    end

    // ready_en_q keeps cmd_ready low while reset is asserted even though IDLE.
    always_comb begin
        cmd_ready   = (state_q == S_IDLE) && ready_en_q;
        wr_ready    = (state_q == S_LOAD);
        rd_valid    = (state_q == S_DUMP_OUT);
        busy        = (state_q != S_IDLE);
        cpu_enable  = (state_q == S_RUN);
        done        = done_q;
        rd_data     = rd_data_q;
        addr_ext    = '0;
        wen_ext     = 1'b0;
        ren_ext     = 1'b0;
        wdata_ext   = '0;
        addr_ext_2  = '0;
        wen_ext_2   = 1'b0;
        ren_ext_2   = 1'b0;
        wdata_ext_2 = '0;
        if (wr_fire) begin
            if (op_q == OP_LOAD_I) begin
                addr_ext  = imem_addr;
                wen_ext   = 1'b1;
                wdata_ext = wr_data[31:0];
            end else begin
                addr_ext_2  = dmem_addr;
                wen_ext_2   = 1'b1;
                wdata_ext_2 = wr_data;
            end
        end
        if (state_q == S_DUMP_RD) begin
            addr_ext_2 = dmem_addr;
            ren_ext_2  = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_loader_ctrl.sv
`default_nettype none
// tb_mem_loader_ctrl: table vectors, corner sequences and random commands
// checked against a transaction-level model of the loader.
module tb_mem_loader_ctrl;

    localparam int         LEN_W   = 32;
    localparam logic [1:0] OP_LI   = 2'b00;
    localparam logic [1:0] OP_LD   = 2'b01;
    localparam logic [1:0] OP_RUN  = 2'b10;
    localparam logic [1:0] OP_DUMP = 2'b11;

    logic             clk = 1'b0;
    logic             arst_n = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [1:0]       cmd_op = 2'b00;
    logic [63:0]      cmd_addr = 64'd0;
    logic [LEN_W-1:0] cmd_len = '0;
    logic             wr_valid = 1'b0;
    logic             wr_ready;
    logic [63:0]      wr_data = 64'd0;
    logic             rd_valid;
    logic             rd_ready = 1'b0;
    logic [63:0]      rd_data;
    logic             busy, done, cpu_enable;
    logic [63:0]      addr_ext;
    logic             wen_ext, ren_ext;
    logic [31:0]      wdata_ext;
    logic [31:0]      rdata_ext = 32'd0;
    logic [63:0]      addr_ext_2;
    logic             wen_ext_2, ren_ext_2;
    logic [63:0]      wdata_ext_2;
    logic [63:0]      rdata_ext_2 = 64'd0;

    mem_loader_ctrl #(.IMEM_STEP(4), .DMEM_STEP(8), .LEN_W(LEN_W)) dut (
        .clk(clk), .arst_n(arst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .busy(busy), .done(done), .cpu_enable(cpu_enable),
        .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext),
        .wdata_ext(wdata_ext), .rdata_ext(rdata_ext),
        .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2), .ren_ext_2(ren_ext_2),
        .wdata_ext_2(wdata_ext_2), .rdata_ext_2(rdata_ext_2)
    );

    always #5 clk = ~clk;

    // Memories attached to the external ports (1-cycle read latency).
    logic [31:0] imem [logic [63:0]];
    logic [63:0] dmem [logic [63:0]];
    always @(posedge clk) begin
        if (wen_ext)   imem[addr_ext] = wdata_ext;
        if (wen_ext_2) dmem[addr_ext_2] = wdata_ext_2;
        if (ren_ext)   rdata_ext <= imem.exists(addr_ext) ? imem[addr_ext] : 32'd0;
        if (ren_ext_2) rdata_ext_2 <= dmem.exists(addr_ext_2) ? dmem[addr_ext_2] : 64'd0;
    end

    // Reference model: expected transactions per port and dmem contents.
    typedef struct { logic [63:0] a; logic [63:0] d; } wr_t;
    wr_t         exp_wi[$];
    wr_t         exp_wd[$];
    logic [63:0] exp_ren[$];
    logic [63:0] exp_rd[$];
    logic [63:0] ref_d [logic [63:0]];
    logic [63:0] pre_words[$];

    int n_cmp = 0, n_bad = 0;
    int cnt_wi = 0, cnt_wd = 0, cnt_ren = 0, cnt_en = 0, cnt_done = 0, cnt_ri = 0;
    int cyc = 0, n_cmds = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
        end
    endtask

    task automatic expect_true(input string name, input logic cond);
        n_cmp++;
        if (cond !== 1'b1) begin
            n_bad++;
            $display("FAIL %s: got %b required 1", name, cond);
        end
    endtask

    wr_t         e_m;
    logic [63:0] a_m;
    logic        prev_hold = 1'b0;
    logic [63:0] prev_rd = 64'd0;
    always @(negedge clk) begin
        if (arst_n) begin
            if (wen_ext) begin
                cnt_wi++;
                expect_true("wen_i_expected", exp_wi.size() != 0);
                if (exp_wi.size() != 0) begin
                    e_m = exp_wi.pop_front();
                    check("wen_i_addr", addr_ext, e_m.a);
                    check("wen_i_data", {32'd0, wdata_ext}, e_m.d);
                    check("wen_i_other_port", addr_ext_2 | wdata_ext_2, 64'd0);
                end
            end
            if (wen_ext_2) begin
                cnt_wd++;
                expect_true("wen_d_expected", exp_wd.size() != 0);
                if (exp_wd.size() != 0) begin
                    e_m = exp_wd.pop_front();
                    check("wen_d_addr", addr_ext_2, e_m.a);
                    check("wen_d_data", wdata_ext_2, e_m.d);
                    check("wen_d_other_port", addr_ext | {32'd0, wdata_ext}, 64'd0);
                end
            end
            if (ren_ext_2) begin
                cnt_ren++;
                expect_true("ren_d_expected", exp_ren.size() != 0);
                if (exp_ren.size() != 0) begin
                    a_m = exp_ren.pop_front();
                    check("ren_d_addr", addr_ext_2, a_m);
                end
            end
            if (ren_ext) cnt_ri++;
            if (rd_valid && prev_hold) check("rd_data_hold", rd_data, prev_rd);
            if (rd_valid && rd_ready) begin
                expect_true("rd_expected", exp_rd.size() != 0);
                if (exp_rd.size() != 0) begin
                    a_m = exp_rd.pop_front();
                    check("rd_data", rd_data, a_m);
                end
            end
            if (cpu_enable) begin
                cnt_en++;
                expect_true("run_quiet", !(wen_ext | wen_ext_2 | ren_ext | ren_ext_2 |
                                           cmd_ready | wr_ready | rd_valid));
            end
            if (done) cnt_done++;
            prev_hold = rd_valid && !rd_ready;
            prev_rd   = rd_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic issue(input logic [1:0] op, input logic [63:0] addr, input int len);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_len   = LEN_W'(len);
        while (!cmd_ready && n < 100) begin
            tick();
            n++;
        end
        expect_true("cmd_accept", cmd_ready);
        tick();
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom);
        cmd_addr  = {$urandom, $urandom};
        cmd_len   = LEN_W'($urandom);
    endtask

    task automatic model_cmd(input logic [1:0] op, input logic [63:0] addr, input int len,
                             input logic [63:0] words[$]);
        wr_t t;
        logic [63:0] a;
        for (int k = 0; k < len; k++) begin
            case (op)
                OP_LI: begin
                    t.a = addr + 64'(k) * 64'd4;
                    t.d = {32'd0, words[k][31:0]};
                    exp_wi.push_back(t);
                end
                OP_LD: begin
                    t.a = addr + 64'(k) * 64'd8;
                    t.d = words[k];
                    exp_wd.push_back(t);
                    ref_d[t.a] = words[k];
                end
                OP_DUMP: begin
                    a = addr + 64'(k) * 64'd8;
                    exp_ren.push_back(a);
                    exp_rd.push_back(ref_d.exists(a) ? ref_d[a] : 64'd0);
                end
                default: ;
            endcase
        end
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic [63:0] addr, input int len,
                           input int gap, input int stall, input logic [63:0] d0,
                           input logic [63:0] dinc, input bit rnd,
                           input int e_wi, input int e_wd, input int e_ren, input int e_en,
                           input int e_lat);
        logic [63:0] words[$];
        int s_wi = cnt_wi, s_wd = cnt_wd, s_ren = cnt_ren, s_en = cnt_en;
        int c0, n;
        for (int k = 0; k < len; k++) begin
            if (pre_words.size() != 0)  words.push_back(pre_words.pop_front());
            else if (rnd)               words.push_back({$urandom, $urandom});
            else                        words.push_back(d0 + 64'(k) * dinc);
        end
        model_cmd(op, addr, len, words);
        issue(op, addr, len);
        c0 = cyc;
        if (op == OP_LI || op == OP_LD) begin
            for (int k = 0; k < len; k++) begin
                repeat (gap) begin
                    rd_ready = 1'($urandom);
                    tick();
                end
                rd_ready = 1'b0;
                expect_true("wr_ready", wr_ready);
                wr_valid = 1'b1;
                wr_data  = words[k];
                tick();
                wr_valid = 1'b0;
                wr_data  = {$urandom, $urandom};
            end
        end else if (op == OP_DUMP) begin
            for (int k = 0; k < len; k++) begin
                n = 0;
                while (!rd_valid && n < 50) begin
                    wr_valid = 1'($urandom);
                    tick();
                    n++;
                end
                wr_valid = 1'b0;
                expect_true("rd_valid", rd_valid);
                repeat (stall) tick();
                rd_ready = 1'b1;
                tick();
                rd_ready = 1'b0;
            end
        end
        n = 0;
        while (!done && n < 5000) begin
            if (op == OP_RUN) begin
                wr_valid = 1'($urandom);
                rd_ready = 1'($urandom);
            end
            tick();
            n++;
        end
        wr_valid = 1'b0;
        rd_ready = 1'b0;
        expect_true("done_seen", done);
        n_cmds++;
        check("latency", 64'(cyc - c0 + 1), 64'(e_lat));
        check("wen_i_count", 64'(cnt_wi - s_wi), 64'(e_wi));
        check("wen_d_count", 64'(cnt_wd - s_wd), 64'(e_wd));
        check("ren_d_count", 64'(cnt_ren - s_ren), 64'(e_ren));
        check("enable_count", 64'(cnt_en - s_en), 64'(e_en));
    endtask

    task automatic check_reset_outputs(input string name);
        check(name, 64'({cmd_ready, wr_ready, rd_valid, busy, done, cpu_enable,
                         wen_ext, ren_ext, wen_ext_2, ren_ext_2}), 64'd0);
        check({name, "_buses"}, addr_ext | addr_ext_2 | wdata_ext_2 | {32'd0, wdata_ext} | rd_data,
              64'd0);
    endtask

    task automatic release_reset();
        @(negedge clk);
        #1;
        arst_n = 1'b1;
        tick();
        expect_true("ready_after_release", cmd_ready && !busy);
    endtask

    typedef struct {
        logic [1:0] op; logic [63:0] addr; int len; int gap; int stall;
        logic [63:0] d0; logic [63:0] dinc;
        int e_wi; int e_wd; int e_ren; int e_en; int e_lat;
    } vec_t;
    vec_t tbl[11];

    initial begin
        logic [63:0] w[$];
        logic [1:0]  op;
        logic [63:0] addr;
        int          len, gap, stall, lat;

        tbl[0]  = '{OP_LD,   64'h10, 2, 2, 0, 64'hA5A5_0000_0000_0001, 64'd1, 0, 2, 0, 0, 7};
        tbl[1]  = '{OP_RUN,  64'h0,  5, 0, 0, 64'd0, 64'd0,                  0, 0, 0, 5, 6};
        tbl[2]  = '{OP_LD,   64'h0,  4, 0, 0, 64'h11, 64'h11,                 0, 4, 0, 0, 5};
        tbl[3]  = '{OP_DUMP, 64'h0,  4, 0, 3, 64'd0, 64'd0,                  0, 0, 4, 0, 25};
        tbl[4]  = '{OP_LI,   64'h40, 0, 0, 0, 64'd0, 64'd0,                  0, 0, 0, 0, 1};
        tbl[5]  = '{OP_LD,   64'h40, 0, 0, 0, 64'd0, 64'd0,                  0, 0, 0, 0, 1};
        tbl[6]  = '{OP_RUN,  64'h40, 0, 0, 0, 64'd0, 64'd0,                  0, 0, 0, 0, 1};
        tbl[7]  = '{OP_DUMP, 64'h40, 0, 0, 0, 64'd0, 64'd0,                  0, 0, 0, 0, 1};
        tbl[8]  = '{OP_LD,   64'hFFFF_FFFF_FFFF_FFF8, 3, 1, 0, 64'hDEAD_0000_0000_0000, 64'h100,
                    0, 3, 0, 0, 7};
        tbl[9]  = '{OP_DUMP, 64'hFFFF_FFFF_FFFF_FFF0, 4, 0, 0, 64'd0, 64'd0, 0, 0, 4, 0, 13};
        tbl[10] = '{OP_RUN,  64'h0,  1, 0, 0, 64'd0, 64'd0,                  0, 0, 0, 1, 2};

        // Reset state
        tick();
        tick();
        check_reset_outputs("reset_outputs");
        release_reset();

        // Instruction load with known words
        pre_words = '{64'h0000_0000_0050_0093, 64'hFFFF_FFFF_00A0_0113, 64'h1234_5678_0020_81B3};
        run_cmd(OP_LI, 64'h0, 3, 0, 0, 64'd0, 64'd0, 1'b0, 3, 0, 0, 0, 4);
        check("imem_0", {32'd0, imem.exists(64'h0) ? imem[64'h0] : 32'd0}, 64'h0050_0093);
        check("imem_8", {32'd0, imem.exists(64'h8) ? imem[64'h8] : 32'd0}, 64'h0020_81B3);

        for (int i = 0; i < 11; i++) begin
            run_cmd(tbl[i].op, tbl[i].addr, tbl[i].len, tbl[i].gap, tbl[i].stall,
                    tbl[i].d0, tbl[i].dinc, 1'b0,
                    tbl[i].e_wi, tbl[i].e_wd, tbl[i].e_ren, tbl[i].e_en, tbl[i].e_lat);
        end
        check("dmem_0x18", dmem.exists(64'h18) ? dmem[64'h18] : 64'd0, 64'h44);

        // Reset during a load after two of four words
        w = '{{$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}};
        model_cmd(OP_LI, 64'h200, 4, w);
        issue(OP_LI, 64'h200, 4);
        for (int k = 0; k < 2; k++) begin
            wr_valid = 1'b1;
            wr_data  = w[k];
            tick();
        end
        wr_valid = 1'b1;
        wr_data  = w[2];
        #1;
        arst_n = 1'b0;
        #1;
        check_reset_outputs("reset_mid_load");
        check("abort_pending", 64'(exp_wi.size()), 64'd2);
        exp_wi.delete();
        wr_valid = 1'b0;
        release_reset();
        check("partial_kept", {32'd0, imem.exists(64'h204) ? imem[64'h204] : 32'd0}, {32'd0, w[1][31:0]});
        expect_true("partial_not_written", !imem.exists(64'h208));

        // Reset during a run
        issue(OP_RUN, 64'h0, 10);
        tick();
        tick();
        expect_true("run_active", cpu_enable && busy);
        #1;
        arst_n = 1'b0;
        #1;
        check_reset_outputs("reset_mid_run");
        release_reset();

        // Random command stream
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0:       addr = 64'h0;
                1:       addr = 64'h100;
                2:       addr = 64'hFFFF_FFFF_FFFF_FFE0;
                default: addr = {$urandom, $urandom};
            endcase
            len   = (op == OP_RUN) ? $urandom_range(0, 12) : $urandom_range(0, 6);
            gap   = $urandom_range(0, 2);
            stall = $urandom_range(0, 2);
            if (op == OP_RUN)       lat = len + 1;
            else if (op == OP_DUMP) lat = len * (3 + stall) + 1;
            else                    lat = len * (gap + 1) + 1;
            run_cmd(op, addr, len, gap, stall, 64'd0, 64'd0, 1'b1,
                    (op == OP_LI) ? len : 0, (op == OP_LD) ? len : 0,
                    (op == OP_DUMP) ? len : 0, (op == OP_RUN) ? len : 0, lat);
        end

        tick();
        tick();
        check("done_pulses", 64'(cnt_done), 64'(n_cmds));
        check("ren_i_count", 64'(cnt_ri), 64'd0);
        check("leftover_expectations",
              64'(exp_wi.size() + exp_wd.size() + exp_ren.size() + exp_rd.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
